// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcode, state and mux-select encodings for the multi-cycle core.
// Imported by the sequencer and by the datapath muxes.
package alu_seq_ctrl_pkg;

  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_LDW  = 6'h23;
  localparam logic [5:0] OP_SDW  = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_S2 = 2'd3;

  localparam logic [1:0] PC_SRC_ALU = 2'd0;
  localparam logic [1:0] PC_SRC_TGT = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  function automatic logic is_alu(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_XOR, OP_SLT: is_alu = 1'b1;
      default:               is_alu = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    is_mem = (op == OP_LDW) || (op == OP_SDW);
  endfunction

  function automatic logic op_valid(input logic [5:0] op);
    op_valid = is_alu(op) || is_mem(op) ||
               (op == OP_BEQ) || (op == OP_JUMP);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// Carries IR/flag/memory status in and every mux select and enable out.
interface alu_seq_ctrl_if;
  logic [5:0] ir_opcode;
  logic       zf;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       ir_we;
  logic [5:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       tgt_we;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       retire;
  logic       err;
  logic [2:0] state;

  modport master (
    input  ir_opcode, zf, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we,
    output alu_op, alu_src_a, alu_src_b,
    output pc_we, pc_src, tgt_we,
    output reg_we, reg_dst, mem_to_reg,
    output retire, err, state
  );

  modport slave (
    output ir_opcode, zf, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we,
    input  alu_op, alu_src_a, alu_src_b,
    input  pc_we, pc_src, tgt_we,
    input  reg_we, reg_dst, mem_to_reg,
    input  retire, err, state
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB control with a
// memory-wait timeout that parks the core in a sticky ERR state.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst_n,
  alu_seq_ctrl_if.master bus
);

  localparam int CW = (MEM_TIMEOUT > 0) ?
                      $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          wait_st;
  logic          tmo;
  logic [5:0]    op;

  assign op      = bus.ir_opcode;
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM);
  // Fires on the last allowed wait cycle, overriding a late mem_ready.
  assign tmo     = (MEM_TIMEOUT != 0) && wait_st &&
                   (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (wait_st && !bus.mem_ready) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bus.state = state_q;

  always_comb begin
    state_d          = state_q;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.alu_op       = OP_ADD;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = SRC_B_RT;
    bus.pc_we        = 1'b0;
    bus.pc_src       = PC_SRC_ALU;
    bus.tgt_we       = 1'b0;
    bus.reg_we       = 1'b0;
    bus.reg_dst      = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.retire       = 1'b0;
    bus.err          = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = SRC_B_FOUR;
        if (tmo) begin
          state_d = S_ERR;
        end else if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = SRC_B_IMM_S2;
        bus.tgt_we    = 1'b1;
        state_d       = op_valid(op) ? S_EXEC : S_ERR;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        unique case (1'b1)
          is_mem(op): begin
            bus.alu_op    = op;
            bus.alu_src_b = SRC_B_IMM;
            state_d       = S_MEM;
          end
          is_alu(op): begin
            bus.alu_op = op;
            state_d    = S_WB;
          end
          (op == OP_BEQ): begin
            bus.alu_op = OP_BEQ;
            bus.pc_we  = bus.zf;
            bus.pc_src = PC_SRC_TGT;
            bus.retire = 1'b1;
            state_d    = S_FETCH;
          end
          (op == OP_JUMP): begin
            bus.alu_op = OP_JUMP;
            bus.pc_we  = 1'b1;
            bus.pc_src = PC_SRC_JMP;
            bus.retire = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = (op == OP_SDW);
        if (tmo) begin
          state_d = S_ERR;
        end else if (bus.mem_ready) begin
          if (op == OP_SDW) begin
            bus.retire = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        bus.reg_we     = 1'b1;
        bus.retire     = 1'b1;
        bus.mem_to_reg = (op == OP_LDW);
        bus.reg_dst    = (op != OP_LDW);
        state_d        = S_FETCH;
      end
      S_ERR: begin
        bus.err = 1'b1;
      end
      default: state_d = S_ERR;
    endcase

    // Reset blanks every output at once, not at the next edge.
    if (!rst_n) begin
      state_d          = S_FETCH;
      bus.mem_req      = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_addr_sel = 1'b0;
      bus.ir_we        = 1'b0;
      bus.alu_op       = '0;
      bus.alu_src_a    = 1'b0;
      bus.alu_src_b    = '0;
      bus.pc_we        = 1'b0;
      bus.pc_src       = '0;
      bus.tgt_we       = 1'b0;
      bus.reg_we       = 1'b0;
      bus.reg_dst      = 1'b0;
      bus.mem_to_reg   = 1'b0;
      bus.retire       = 1'b0;
      bus.err          = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized instruction stream for alu_seq_ctrl, checked cycle by
// cycle against a per-phase reference of the control outputs.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic [5:0] op;
    logic       src_a;
    logic [1:0] src_b;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       tgt_we;
    logic       reg_we;
    logic       reg_dst;
    logic       m2r;
    logic       retire;
    logic       err;
  } ov_t;

  localparam int PH_F = 0;
  localparam int PH_D = 1;
  localparam int PH_E = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;
  localparam int PH_X = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   retire_seen = 0;
  int   retire_exp = 0;
  logic [5:0] ops [10];

  alu_seq_ctrl_if bus();

  alu_seq_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.retire) retire_seen++;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ov_t obs();
    ov_t o;
    o.st       = bus.state;
    o.mem_req  = bus.mem_req;
    o.mem_we   = bus.mem_we;
    o.addr_sel = bus.mem_addr_sel;
    o.ir_we    = bus.ir_we;
    o.op       = bus.alu_op;
    o.src_a    = bus.alu_src_a;
    o.src_b    = bus.alu_src_b;
    o.pc_we    = bus.pc_we;
    o.pc_src   = bus.pc_src;
    o.tgt_we   = bus.tgt_we;
    o.reg_we   = bus.reg_we;
    o.reg_dst  = bus.reg_dst;
    o.m2r      = bus.mem_to_reg;
    o.retire   = bus.retire;
    o.err      = bus.err;
    return o;
  endfunction

  // What the controller must drive in a given phase of an instruction.
  function automatic ov_t model(input int ph, input logic [5:0] op,
                                input logic zf, input logic rdy);
    ov_t o = '0;
    o.op = OP_ADD;
    o.st = 3'(ph);
    case (ph)
      PH_F: begin
        o.mem_req = 1; o.src_b = 2'd1;
        o.ir_we = rdy; o.pc_we = rdy;
      end
      PH_D: begin
        o.src_b = 2'd3; o.tgt_we = 1;
      end
      PH_E: begin
        o.src_a = 1;
        if (op == OP_LDW || op == OP_SDW) begin
          o.op = op; o.src_b = 2'd2;
        end else if (op == OP_BEQ) begin
          o.op = OP_BEQ; o.pc_we = zf; o.pc_src = 2'd1; o.retire = 1;
        end else if (op == OP_JUMP) begin
          o.op = OP_JUMP; o.pc_we = 1; o.pc_src = 2'd2; o.retire = 1;
        end else begin
          o.op = op;
        end
      end
      PH_M: begin
        o.mem_req = 1; o.addr_sel = 1;
        o.mem_we = (op == OP_SDW);
        o.retire = rdy && (op == OP_SDW);
      end
      PH_W: begin
        o.reg_we = 1; o.retire = 1;
        o.m2r = (op == OP_LDW); o.reg_dst = (op != OP_LDW);
      end
      default: o.err = 1;
    endcase
    return o;
  endfunction

  // One cycle: drive at the falling edge, check, wait for next falling edge.
  task automatic step(input string tag, input int ph, input logic [5:0] op,
                      input logic zf, input logic rdy);
    bus.ir_opcode = op;
    bus.zf        = zf;
    bus.mem_ready = rdy;
    #1;
    chk(tag, 32'(obs()), 32'(model(ph, op, zf, rdy)));
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic zf,
                           input int wf, input int wm);
    logic r;
    for (int i = 0; i <= wf; i++) step("fetch", PH_F, op, zf, i == wf);
    r = 1'($urandom);
    step("decode", PH_D, op, ~zf, r);
    r = 1'($urandom);
    step("exec", PH_E, op, zf, r);
    if (op == OP_LDW || op == OP_SDW)
      for (int i = 0; i <= wm; i++) step("mem", PH_M, op, ~zf, i == wm);
    if (op != OP_BEQ && op != OP_JUMP && op != OP_SDW) begin
      r = 1'($urandom);
      step("wb", PH_W, op, zf, r);
    end
    retire_exp++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk(tag, 32'(obs()), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ops = '{OP_LDW, OP_SDW, OP_BEQ, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR, OP_SLT, OP_JUMP};
    bus.ir_opcode = OP_ADD;
    bus.zf        = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("reset_state", 32'(obs()), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(OP_ADD, 1'b0, 0, 0);
    run_instr(OP_LDW, 1'b0, 0, 2);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    run_instr(OP_JUMP, 1'b0, 1, 0);
    run_instr(OP_SDW, 1'b1, 2, 1);

    for (int n = 0; n < 80; n++) begin
      run_instr(ops[$urandom_range(0, 9)], 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Undefined opcode parks the core in ERR until reset.
    step("bad_fetch", PH_F, 6'h3F, 1'b0, 1'b1);
    step("bad_decode", PH_D, 6'h3F, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++)
      step("err_hold", PH_X, 6'h3F, 1'($urandom), 1'($urandom));
    do_reset("err_reset");
    step("post_err", PH_F, OP_ADD, 1'b0, 1'b0);
    do_reset("pre_tmo");

    // Fetch timeout: four waiting cycles, then ERR with no IR load.
    for (int i = 0; i < 4; i++) step("tmo_fetch", PH_F, OP_ADD, 1'b0, 1'b0);
    step("tmo_err", PH_X, OP_ADD, 1'b0, 1'b0);
    do_reset("tmo_reset");

    // Reset in the middle of a store's memory phase.
    step("st_fetch", PH_F, OP_SDW, 1'b0, 1'b1);
    step("st_decode", PH_D, OP_SDW, 1'b0, 1'b1);
    step("st_exec", PH_E, OP_SDW, 1'b0, 1'b1);
    bus.mem_ready = 1'b0;
    #1;
    chk("st_mem", 32'(obs()), 32'(model(PH_M, OP_SDW, 1'b0, 1'b0)));
    #2;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("st_rst_out", 32'(obs()), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step("st_restart", PH_F, OP_SDW, 1'b0, 1'b0);
    run_instr(OP_ADD, 1'b0, 0, 0);

    chk("retire_count", 32'(retire_seen), 32'(retire_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle control FSM that sequences the shared 32-bit ALU, register file, PC and instruction/data memory port of the CPU. Each instruction runs as FETCH → DECODE → EXEC → (MEM) → (WB). Per state, the block drives the ALU opcode, the ALU operand selects and every datapath write enable. It sits between the instruction register and the datapath muxes and is the only block that writes `alu_op`.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: maximum cycles to wait for `mem_ready` before entering ERR; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `ir_opcode`  in  6  opcode field of the instruction register, valid from DECODE onward
- `zf`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  1 = store, 0 = load/fetch
- `mem_addr_sel`  out  1  0 = PC, 1 = ALU result register
- `ir_we`  out  1  load the instruction register
- `alu_op`  out  6  opcode driven to the ALU, using the shared opcode macros
- `alu_src_a`  out  1  0 = PC, 1 = rs
- `alu_src_b`  out  2  0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate << 2
- `pc_we`  out  1  PC write enable
- `pc_src`  out  2  0 = ALU result, 1 = branch target register, 2 = jump target
- `tgt_we`  out  1  latch the ALU result into the branch target register
- `reg_we`  out  1  register file write enable
- `reg_dst`  out  1  0 = rt, 1 = rd
- `mem_to_reg`  out  1  write-back source: 0 = ALU result, 1 = memory data
- `retire`  out  1  one-cycle pulse when an instruction completes
- `err`  out  1  sticky error flag
- `state`  out  3  current state, for debug

## Operation
- States:
  - FETCH=0
  - DECODE=1
  - EXEC=2
  - MEM=3
  - WB=4
  - ERR=7
- Reset: state=FETCH; all outputs 0 except `state`; the timeout counter is 0.
- FETCH:
  - Drives `mem_req`=1, `mem_addr_sel`=0, `alu_op`=ADD, `alu_src_a`=0, `alu_src_b`=1.
  - When `mem_ready`=1: pulses `ir_we`=1 and `pc_we`=1 with `pc_src`=0 (PC+4), then moves to DECODE.
  - Otherwise holds FETCH, with `ir_we` and `pc_we` held at 0.
- DECODE:
  - Drives `alu_op`=ADD, `alu_src_a`=0, `alu_src_b`=3, `tgt_we`=1.
  - Moves to EXEC if `ir_opcode` is in {LDW, SDW, BEQ, ADD, SUB, AND, OR, XOR, SLT, JUMP}; otherwise moves to ERR.
- EXEC (`alu_src_a`=1):
  - LDW/SDW: `alu_op`=opcode, `alu_src_b`=2; next state MEM.
  - ADD/SUB/AND/OR/XOR/SLT: `alu_op`=opcode, `alu_src_b`=0; next state WB.
  - BEQ: `alu_op`=BEQ, `alu_src_b`=0; `pc_we`=`zf`, `pc_src`=1; `retire`=1; next state FETCH.
  - JUMP: `alu_op`=JUMP; `pc_we`=1, `pc_src`=2; `retire`=1; next state FETCH.
- MEM:
  - Drives `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(opcode==SDW).
  - On `mem_ready`: SDW asserts `retire` and goes to FETCH; LDW goes to WB.
- WB:
  - Drives `reg_we`=1 and `retire`=1; next state FETCH.
  - LDW: `mem_to_reg`=1, `reg_dst`=0.
  - ALU instructions: `mem_to_reg`=0, `reg_dst`=1.
- ERR:
  - All enables 0, `err`=1.
  - Leaves ERR only on reset.
- Timeout:
  - The counter increments each cycle in FETCH or MEM while `mem_ready`=0, and clears on any state change.
  - If `MEM_TIMEOUT`≠0 and the counter reaches `MEM_TIMEOUT`, the next state is ERR, even if `mem_ready` rises in the same cycle.
- `alu_op` defaults to ADD in every state without an explicit assignment.
- `ir_opcode` is sampled combinationally. The IR changes only at the end of FETCH, so it is stable from DECODE to WB.

## Timing
- Registered state; all outputs are Moore/Mealy combinational from state, `ir_opcode`, `zf` and `mem_ready`, with no extra latency.
- Cycles per instruction with `mem_ready` tied high:
  - BEQ and JUMP: 3
  - ALU ops and SDW: 4
  - LDW: 5
- Each cycle of `mem_ready`=0 in FETCH or MEM adds exactly one cycle.
- `mem_req` stays high from the first cycle of FETCH or MEM until the `mem_ready` cycle inclusive. It never drops while waiting.
- `retire` is high for exactly one cycle per instruction; it is never high in FETCH, DECODE or ERR.
- Asserting `rst_n` low mid-instruction forces FETCH and all outputs to 0 immediately, asynchronously. A partial store may have been issued; no register write occurs after reset is asserted.

## Structure
- The shared definitions header holds:
  - the opcode macros (already used by the ALU);
  - new macros for the state encodings and the `alu_src_b`/`pc_src` select codes, so the datapath muxes use the same names.
- A single module, with no sub-module. The timeout counter is inline: an 8-bit register, sized by `$clog2(MEM_TIMEOUT+1)`.

## Test plan
- ADD, `mem_ready`=1: states 0,1,2,4. In EXEC, `alu_op`=ADD and `alu_src_b`=0. In WB, `reg_we`=1, `reg_dst`=1, `retire`=1. Total 4 cycles.
- LDW with `mem_ready` low for 2 cycles in MEM: `mem_req` is held for 3 MEM cycles, then WB with `mem_to_reg`=1. Total 7 cycles and one `retire`.
- BEQ with `zf`=1, then `zf`=0: `pc_we`=1 with `pc_src`=1 in the first case; `pc_we`=0 in the second. Both retire in EXEC, 3 cycles each.
- Undefined opcode 6'b111111: DECODE→ERR, `err`=1, all enables stay 0 for 20 cycles. Pulling `rst_n` low then high returns to FETCH with `err`=0.
- `MEM_TIMEOUT`=4, `mem_ready` stuck at 0 in FETCH: ERR is entered 4 cycles after entering FETCH; `ir_we` is never asserted.
- Reset asserted in MEM of an SDW: outputs go to 0 within the same cycle, with no `retire`. After release, FETCH restarts with `mem_we`=0.
